// File: rtl/gb_lcd_capture_if.sv
// Framebuffer write port of the Game Boy LCD capture block.
// The capture side drives it (master); the framebuffer RAM consumes it (slave).
interface gb_lcd_capture_if;
    logic [14:0] wraddress;
    logic [1:0]  wdata;
    logic        wren;

    modport master (output wraddress, output wdata, output wren);
    modport slave  (input  wraddress, input  wdata, input  wren);
endinterface

// File: rtl/gb_lcd_capture.sv
// Game Boy LCD capture: synchronizes the asynchronous LCD bus into pllclk,
// detects pixel/line/frame edges and writes pixels into a linear framebuffer,
// flagging frames that do not have exactly V_LINES lines of H_PIX pixels.
module gb_lcd_capture #(
    parameter int H_PIX       = 160,
    parameter int V_LINES     = 144,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iclk,
    input  logic              ihsync,
    input  logic              ivsync,
    input  logic [1:0]        idata,
    gb_lcd_capture_if.master  fb,
    output logic              frame_done,
    output logic              frame_ok,
    output logic [7:0]        err_count
);

    localparam int CW   = $clog2(H_PIX + 1);
    localparam int RW   = $clog2(V_LINES + 1);
    localparam int WARM = SYNC_STAGES + 2;
    localparam int WW   = $clog2(WARM + 1);

    localparam logic [CW-1:0] COL_MAX   = CW'(H_PIX);
    localparam logic [RW-1:0] ROW_MAX   = RW'(V_LINES);
    localparam logic [14:0]   BASE_STEP = 15'(H_PIX);
    localparam logic [WW-1:0] WARM_DONE = WW'(WARM);

    typedef enum logic {
        WAIT_VSYNC,
        ACTIVE
    } state_t;

    logic [SYNC_STAGES-1:0]      clk_sync, hs_sync, vs_sync;
    logic [SYNC_STAGES-1:0][1:0] dat_sync;
    logic                        clk_d1, clk_d2, hs_d1, hs_d2, vs_d1, vs_d2;
    logic [1:0]                  dat_d1, pix_data;
    logic                        pix_ev, line_ev, frame_ev;
    logic [WW-1:0]               warm;

    state_t                      state;
    logic [CW-1:0]               col, col_after;
    logic [RW-1:0]               row;
    logic [14:0]                 base;
    logic                        frame_err;
    logic                        pix_fits;

    // Synchronizers, delayed copies and registered edge pulses. Edge output is
    // held off until the delayed copies have filled after reset, so a level
    // already high at reset release is not mistaken for a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '0;
            hs_sync  <= '0;
            vs_sync  <= '0;
            dat_sync <= '0;
            clk_d1   <= 1'b0;
            clk_d2   <= 1'b0;
            hs_d1    <= 1'b0;
            hs_d2    <= 1'b0;
            vs_d1    <= 1'b0;
            vs_d2    <= 1'b0;
            dat_d1   <= '0;
            pix_data <= '0;
            pix_ev   <= 1'b0;
            line_ev  <= 1'b0;
            frame_ev <= 1'b0;
            warm     <= '0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], iclk};
            hs_sync  <= {hs_sync[SYNC_STAGES-2:0], ihsync};
            vs_sync  <= {vs_sync[SYNC_STAGES-2:0], ivsync};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], idata};
            clk_d1   <= clk_sync[SYNC_STAGES-1];
            clk_d2   <= clk_d1;
            hs_d1    <= hs_sync[SYNC_STAGES-1];
            hs_d2    <= hs_d1;
            vs_d1    <= vs_sync[SYNC_STAGES-1];
            vs_d2    <= vs_d1;
            dat_d1   <= dat_sync[SYNC_STAGES-1];
            pix_data <= dat_d1;
            if (warm != WARM_DONE) begin
                warm <= warm + WW'(1);
            end
            pix_ev   <= (warm == WARM_DONE) && clk_d1 && !clk_d2;
            line_ev  <= (warm == WARM_DONE) && hs_d1 && !hs_d2;
            frame_ev <= (warm == WARM_DONE) && vs_d1 && !vs_d2;
        end
    end

    // Column position after this cycle's pixel, so a same-cycle line strobe
    // length-checks the line including that pixel.
    always_comb begin
        pix_fits  = (col < COL_MAX) && (row < ROW_MAX);
        col_after = (pix_ev && pix_fits) ? col + CW'(1) : col;
    end

    // Capture FSM: frame framing, pixel writes, line stepping and frame status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT_VSYNC;
            fb.wren      <= 1'b0;
            fb.wraddress <= '0;
            fb.wdata     <= '0;
            frame_done   <= 1'b0;
            frame_ok     <= 1'b0;
            err_count    <= '0;
            col          <= '0;
            row          <= '0;
            base         <= '0;
            frame_err    <= 1'b0;
        end else begin
            fb.wren    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                WAIT_VSYNC: begin
                    if (frame_ev) begin
                        state     <= ACTIVE;
                        col       <= '0;
                        row       <= '0;
                        base      <= '0;
                        frame_err <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (frame_ev) begin
                        frame_done <= 1'b1;
                        if (row == ROW_MAX && col == '0 && !frame_err) begin
                            frame_ok <= 1'b1;
                        end else begin
                            frame_ok <= 1'b0;
                            if (err_count != '1) begin
                                err_count <= err_count + 8'd1;
                            end
                        end
                        col       <= '0;
                        row       <= '0;
                        base      <= '0;
                        frame_err <= 1'b0;
                    end else begin
                        if (pix_ev) begin
                            if (pix_fits) begin
                                fb.wren      <= 1'b1;
                                fb.wraddress <= base + 15'(col);
                                fb.wdata     <= pix_data;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                        if (line_ev) begin
                            if (col_after != COL_MAX) begin
                                frame_err <= 1'b1;
                            end
                            col <= '0;
                            if (row != ROW_MAX) begin
                                row  <= row + RW'(1);
                                base <= base + BASE_STEP;
                            end
                        end else begin
                            col <= col_after;
                        end
                    end
                end
                default: state <= WAIT_VSYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Testbench for gb_lcd_capture: drives LCD-level pixel/line/frame events and
// checks framebuffer writes and frame status against a frame-level model.
module tb_gb_lcd_capture;

    localparam int H  = 160;
    localparam int V  = 10;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iclk = 1'b0;
    logic       ihsync = 1'b0;
    logic       ivsync = 1'b0;
    logic [1:0] idata = '0;
    logic       frame_done;
    logic       frame_ok;
    logic [7:0] err_count;

    gb_lcd_capture_if fb ();

    gb_lcd_capture #(
        .H_PIX      (H),
        .V_LINES    (V),
        .SYNC_STAGES(SS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .iclk      (iclk),
        .ihsync    (ihsync),
        .ivsync    (ivsync),
        .idata     (idata),
        .fb        (fb),
        .frame_done(frame_done),
        .frame_ok  (frame_ok),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Frame-level reference model: expected writes {addr, data} and
    // expected frame results {ok, err_count}.
    logic [16:0] wq[$];
    logic [8:0]  fq[$];
    bit          m_active = 0;
    int          m_len = 0;
    int          m_lines = 0;
    bit          m_bad = 0;
    int          m_errs = 0;
    int          nwr = 0;
    logic [31:0] last_addr = '0;

    task automatic m_clear_frame();
        m_len   = 0;
        m_lines = 0;
        m_bad   = 0;
    endtask

    task automatic m_reset();
        wq.delete();
        fq.delete();
        m_active = 0;
        m_errs   = 0;
        m_clear_frame();
    endtask

    task automatic m_pixel(logic [1:0] d);
        int addr;
        if (m_active) begin
            if (m_lines >= V) begin
                m_bad = 1;
            end else if (m_len < H) begin
                addr = m_lines * H + m_len;
                wq.push_back({addr[14:0], d});
            end
            m_len++;
        end
    endtask

    task automatic m_line();
        if (m_active) begin
            if (m_lines >= V || m_len != H) m_bad = 1;
            m_lines++;
            m_len = 0;
        end
    endtask

    task automatic m_frame();
        bit ok;
        if (!m_active) begin
            m_active = 1;
        end else begin
            ok = !m_bad && (m_lines == V) && (m_len == 0);
            if (!ok && m_errs < 255) m_errs++;
            fq.push_back({ok, m_errs[7:0]});
        end
        m_clear_frame();
    endtask

    // Output monitor, sampled 1 time unit after the active clock edge.
    always @(posedge clk) begin
        logic [16:0] w;
        logic [8:0]  f;
        #1;
        if (fb.wren === 1'b1) begin
            nwr++;
            last_addr = 32'(fb.wraddress);
            if (wq.size() == 0) begin
                check_eq("wr_queue_nonempty", wq.size(), 1);
            end else begin
                w = wq.pop_front();
                check_eq("wr_addr", fb.wraddress, w[16:2]);
                check_eq("wr_data", fb.wdata, w[1:0]);
            end
        end
        if (frame_done === 1'b1) begin
            if (fq.size() == 0) begin
                check_eq("frame_queue_nonempty", fq.size(), 1);
            end else begin
                f = fq.pop_front();
                check_eq("frame_ok", frame_ok, f[8]);
                check_eq("err_count", err_count, f[7:0]);
            end
        end
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    // One LCD event slot: strobes high for one clk, then low for one clk.
    task automatic ev(bit p, bit h, bit v, logic [1:0] d);
        @(negedge clk);
        iclk = p; ihsync = h; ivsync = v; idata = d;
        if (v) begin
            m_frame();
        end else begin
            if (p) m_pixel(d);
            if (h) m_line();
        end
        @(negedge clk);
        iclk = 1'b0; ihsync = 1'b0; ivsync = 1'b0;
    endtask

    task automatic send_line(int len, bit coincide, bit colpat);
        logic [1:0] d;
        for (int c = 0; c < len; c++) begin
            d = colpat ? 2'(c % 4) : 2'($urandom_range(0, 3));
            ev(1'b1, coincide && (c == len - 1), 1'b0, d);
        end
        if (!coincide || len == 0) ev(1'b0, 1'b1, 1'b0, 2'b00);
    endtask

    task automatic lat_pixel(logic [1:0] d);
        int i;
        @(negedge clk);
        iclk = 1'b1; idata = d;
        m_pixel(d);
        for (i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) iclk = 1'b0;
            if (fb.wren === 1'b1) break;
        end
        check_eq("wren_latency", i - 1, SS + 2);
        @(negedge clk);
        check_eq("wren_single_cycle", fb.wren, 0);
    endtask

    task automatic rand_frame();
        int nl;
        int len;
        nl = V - 1 + $urandom_range(0, 2);
        for (int r = 0; r < nl; r++) begin
            len = ($urandom_range(0, 5) == 0) ? H - 1 + $urandom_range(0, 2) : H;
            send_line(len, $urandom_range(0, 2) == 0, 1'b0);
        end
        if ($urandom_range(0, 4) == 0) ev(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
        ev($urandom_range(0, 3) == 0, 1'b0, 1'b1, 2'($urandom_range(0, 3)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (4) @(negedge clk);
        check_eq("rst_wren", fb.wren, 0);
        check_eq("rst_wraddress", fb.wraddress, 0);
        check_eq("rst_wdata", fb.wdata, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_frame_ok", frame_ok, 0);
        check_eq("rst_err_count", err_count, 0);
        rst = 1'b0;
        idle(8);

        // Pixels and lines before the first frame strobe are ignored.
        for (int k = 0; k < 5; k++) ev(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
        ev(1'b0, 1'b1, 1'b0, 2'b00);
        idle(8);
        check_eq("no_write_before_vsync", nwr, 0);

        // Full well-formed frame with data = col % 4.
        ev(1'b0, 1'b0, 1'b1, 2'b00);
        for (int r = 0; r < V; r++) send_line(H, 1'b0, 1'b1);
        ev(1'b0, 1'b0, 1'b1, 2'b00);
        idle(10);
        check_eq("full_write_count", nwr, H * V);
        check_eq("full_last_addr", last_addr, H * V - 1);
        check_eq("full_frame_ok", frame_ok, 1);
        check_eq("full_err_count", err_count, 0);

        // Last pixel of some lines coincident with the line strobe.
        for (int r = 0; r < V; r++) send_line(H, (r % 3) == 1, 1'b0);
        ev(1'b0, 1'b0, 1'b1, 2'b00);

        // One line of H+1 pixels.
        for (int r = 0; r < V; r++) send_line((r == 2) ? H + 1 : H, 1'b0, 1'b0);
        ev(1'b0, 1'b0, 1'b1, 2'b00);

        // One line short, then a good frame.
        for (int r = 0; r < V - 1; r++) send_line(H, 1'b0, 1'b0);
        ev(1'b0, 1'b0, 1'b1, 2'b00);
        for (int r = 0; r < V; r++) send_line(H, 1'b0, 1'b0);
        ev(1'b0, 1'b0, 1'b1, 2'b00);
        idle(10);
        check_eq("good_after_short_ok", frame_ok, 1);
        check_eq("good_after_short_errs", err_count, 2);

        // Single-sample pixel latency at the start of a frame.
        lat_pixel(2'b10);
        ev(1'b0, 1'b0, 1'b1, 2'b00);

        // Randomized frames.
        for (int k = 0; k < 4; k++) rand_frame();

        // Frame strobe together with a pixel: pixel dropped.
        ev(1'b1, 1'b0, 1'b1, 2'b11);
        for (int r = 0; r < V; r++) send_line(H, 1'b0, 1'b0);
        ev(1'b1, 1'b1, 1'b1, 2'b01);
        idle(10);

        // Reset mid-line with iclk and ivsync held high through release.
        for (int k = 0; k < 10; k++) ev(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
        @(negedge clk);
        rst = 1'b1; iclk = 1'b1; ivsync = 1'b1;
        m_reset();
        idle(2);
        check_eq("midrst_err_count", err_count, 0);
        check_eq("midrst_frame_ok", frame_ok, 0);
        check_eq("midrst_wren", fb.wren, 0);
        rst = 1'b0;
        idle(SS + 8);
        iclk = 1'b0; ivsync = 1'b0;
        nwr = 0;
        for (int k = 0; k < 5; k++) ev(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
        ev(1'b0, 1'b1, 1'b0, 2'b00);
        idle(8);
        check_eq("no_write_after_rst", nwr, 0);
        ev(1'b0, 1'b0, 1'b1, 2'b00);
        ev(1'b1, 1'b0, 1'b0, 2'b01);
        idle(8);
        check_eq("first_write_count", nwr, 1);
        check_eq("first_write_addr", last_addr, 0);

        // Many malformed frames: error count saturates.
        for (int k = 0; k < 300; k++) ev(1'b0, 1'b0, 1'b1, 2'b00);
        idle(10);
        check_eq("err_saturate", err_count, 255);
        check_eq("err_model", err_count, m_errs);

        idle(20);
        check_eq("writes_drained", wq.size(), 0);
        check_eq("frames_drained", fq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
